// File: rtl/tiny8_types.sv
// rtl/tiny8_types.sv - shared types for the tiny8 memory controller
// Purpose: controller state and operation enums, plus the wait counter width.
// Ports: none (package).
package tiny8_types;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    WAIT,
    RESP
  } memctl_state;

  typedef enum logic {
    MEM_OP_READ,
    MEM_OP_WRITE
  } mem_op_e;

  // Wide enough for TIMEOUT up to 255; the counter saturates at all ones.
  localparam int CNT_W = 8;

endpackage

// File: rtl/mem_ctrl_if.sv
// rtl/mem_ctrl_if.sv - request-side and external-side bus bundle for mem_ctrl
// Purpose: groups the control request handshake and the external memory bus.
// Ports (modport slave = controller view):
//   in : mem_read, mem_write, mem_address, mem_wdata, ext_rdata, ext_ready
//   out: mem_rdata, mem_resp, mem_error, ext_cs, ext_we, ext_addr, ext_wdata
// The master modport is the mirror image (requester plus external memory).
interface mem_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_resp;
  logic              mem_error;
  logic              ext_cs;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic [DATA_W-1:0] ext_rdata;
  logic              ext_ready;

  modport slave (
    input  mem_read, mem_write, mem_address, mem_wdata, ext_rdata, ext_ready,
    output mem_rdata, mem_resp, mem_error, ext_cs, ext_we, ext_addr, ext_wdata
  );

  modport master (
    output mem_read, mem_write, mem_address, mem_wdata, ext_rdata, ext_ready,
    input  mem_rdata, mem_resp, mem_error, ext_cs, ext_we, ext_addr, ext_wdata
  );
endinterface

// File: rtl/mem_ctrl_wait_timer.sv
// rtl/mem_ctrl_wait_timer.sv - wait-state counter with minimum and timeout flags
// Purpose: counts cycles spent in WAIT; module name mem_wait_timer.
// Ports: clk, rst (async active-high); clear (zero the count), enable (count up);
//        min_reached (count >= MIN_WAIT), timed_out (count >= TIMEOUT).
module mem_wait_timer
  import tiny8_types::*;
#(
  parameter int MIN_WAIT = 1,
  parameter int TIMEOUT  = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic min_reached,
  output logic timed_out
);
  logic [CNT_W-1:0] cnt;

  // Saturating so an indefinite wait never wraps back below MIN_WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign min_reached = (cnt >= CNT_W'(MIN_WAIT));
  assign timed_out   = (cnt >= CNT_W'(TIMEOUT));
endmodule

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - single-outstanding external memory access controller
// Purpose: turns a held read/write request into a SETUP/WAIT/RESP external
//          access and returns a one-cycle mem_resp pulse.
// Ports: clk, rst (async active-high); bus (mem_ctrl_if.slave) carrying the
//        request handshake and the external memory bus.
// Optional feature: TINY8_MEMCTL_TIMEOUT_EN enables the WAIT timeout that
//        completes with mem_error=1 (and all-ones read data) after TIMEOUT cycles.
module mem_ctrl
  import tiny8_types::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int MIN_WAIT = 1,
  parameter int TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        rst,
  mem_ctrl_if.slave   bus
);
  memctl_state       state, state_nx;
  mem_op_e           op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              min_reached, timed_out;
  logic              ready_ok, timeout_hit, cs, resp;

  mem_wait_timer #(
    .MIN_WAIT(MIN_WAIT),
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .clear      (state != WAIT),
    .enable     (state == WAIT),
    .min_reached(min_reached),
    .timed_out  (timed_out)
  );

  // ext_ready only counts once the mandatory wait cycles have elapsed.
  assign ready_ok = min_reached && bus.ext_ready;

`ifdef TINY8_MEMCTL_TIMEOUT_EN
  logic err_q;
  // A qualifying ready in the timeout cycle still wins over the timeout.
  assign timeout_hit = timed_out && !ready_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if ((state == WAIT) && (ready_ok || timeout_hit)) begin
      err_q <= timeout_hit;
    end
  end
  assign bus.mem_error = err_q;
`else
  logic unused_timed_out;
  assign unused_timed_out = timed_out;
  assign timeout_hit      = 1'b0;
  assign bus.mem_error    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cs       = 1'b0;
    resp     = 1'b0;
    case (state)
      IDLE:  if (bus.mem_read || bus.mem_write) state_nx = SETUP;
      SETUP: begin
        cs       = 1'b1;
        state_nx = WAIT;
      end
      WAIT: begin
        cs = 1'b1;
        if (ready_ok || timeout_hit) state_nx = RESP;
      end
      RESP: begin
        resp     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Request fields are captured once in IDLE; later input changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= MEM_OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if ((state == IDLE) && (bus.mem_read || bus.mem_write)) begin
        op_q    <= bus.mem_write ? MEM_OP_WRITE : MEM_OP_READ;
        addr_q  <= bus.mem_address;
        wdata_q <= bus.mem_wdata;
      end
      if ((state == WAIT) && (op_q == MEM_OP_READ)) begin
        if (ready_ok) begin
          rdata_q <= bus.ext_rdata;
        end else if (timeout_hit) begin
          rdata_q <= '1;
        end
      end
    end
  end

  assign bus.ext_cs    = cs;
  assign bus.ext_we    = cs && (op_q == MEM_OP_WRITE);
  assign bus.ext_addr  = addr_q;
  assign bus.ext_wdata = wdata_q;
  assign bus.mem_rdata = rdata_q;
  assign bus.mem_resp  = resp;
endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - scoreboard bench for mem_ctrl
// Build option: TINY8_MEMCTL_TIMEOUT_EN selects the timeout expectations.
module tb_mem_ctrl;
  localparam int AW       = 8;
  localparam int DW       = 8;
  localparam int MIN_WAIT = 1;
  localparam int TIMEOUT  = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_ctrl #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .MIN_WAIT(MIN_WAIT),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       err;
    int         at;
  } exp_t;

  exp_t       sb[$];
  exp_t       m_e;
  int         vec = 0;
  int         miscmp = 0;
  int         cyc = 0;
  int         done_cnt = 0;
  int         issued = 0;
  int         r_cur = 0;
  int         cs_cnt = 0;
  logic [7:0] cur_rd = 8'h00;
  logic [7:0] model_rdata = 8'h00;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // External memory: ready rises once chip select has been high r_cur cycles;
  // read data is garbage whenever ready is low.
  always @(posedge clk) begin
    #1;
    if (bus.ext_cs === 1'b1) begin
      bus.ext_ready = (cs_cnt >= r_cur);
      cs_cnt++;
    end else begin
      cs_cnt = 0;
      bus.ext_ready = 1'($urandom_range(0, 1));
    end
    bus.ext_rdata = bus.ext_ready ? cur_rd : 8'($urandom);
  end

  // Monitor: checks the external bus during an access and every completion.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (bus.ext_cs === 1'b1) begin
        if (sb.size() == 0) begin
          check("cs_without_request", 1, 0);
        end else begin
          check("ext_we", bus.ext_we, sb[0].we);
          check("ext_addr", bus.ext_addr, sb[0].addr);
          check("ext_wdata", bus.ext_wdata, sb[0].wdata);
        end
      end
      if (bus.mem_resp === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_resp", 1, 0);
        end else begin
          m_e = sb.pop_front();
          check("resp_cycle", cyc, m_e.at);
          check("mem_rdata", bus.mem_rdata, m_e.rdata);
          check("mem_error", bus.mem_error, m_e.err);
          check("cs_in_resp", bus.ext_cs, 0);
          done_cnt++;
        end
      end
    end
  end

  // Reference: WAIT cycle j sees chip select high for j+1 cycles, so the
  // access leaves WAIT at j = max(MIN_WAIT, r-1) and responds 3+j cycles
  // after the request cycle.
  task automatic issue(input bit rd, input bit wr, input logic [7:0] a,
                       input logic [7:0] wd, input logic [7:0] rx, input int r);
    exp_t e;
    int   j;
    j     = (r - 1 > MIN_WAIT) ? r - 1 : MIN_WAIT;
    e.err = 1'b0;
`ifdef TINY8_MEMCTL_TIMEOUT_EN
    if (j > TIMEOUT) begin
      j     = TIMEOUT;
      e.err = 1'b1;
    end
`endif
    e.we    = wr;
    e.addr  = a;
    e.wdata = wd;
    if (!wr) model_rdata = e.err ? 8'hFF : rx;
    e.rdata = model_rdata;
    e.at    = cyc + 3 + j;
    sb.push_back(e);
    issued++;
    r_cur  = r;
    cur_rd = rx;
    bus.mem_read    = rd;
    bus.mem_write   = wr;
    bus.mem_address = a;
    bus.mem_wdata   = wd;
  endtask

  // Scrambles address/data while the request is in flight.
  task automatic wait_done(input int target);
    for (int n = 0; n < 400; n++) begin
      @(posedge clk);
      #1;
      if (done_cnt >= target) break;
      bus.mem_address = 8'($urandom);
      bus.mem_wdata   = 8'($urandom);
    end
    if (done_cnt < target) check("resp_timeout", done_cnt, target);
  endtask

  task automatic drop();
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
  endtask

  initial begin
    int op;
    int base;
    rst = 1'b1;
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_address = 8'h00;
    bus.mem_wdata = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ext_cs", bus.ext_cs, 0);
    check("rst_ext_we", bus.ext_we, 0);
    check("rst_ext_addr", bus.ext_addr, 0);
    check("rst_ext_wdata", bus.ext_wdata, 0);
    check("rst_mem_resp", bus.mem_resp, 0);
    check("rst_mem_error", bus.mem_error, 0);
    check("rst_mem_rdata", bus.mem_rdata, 0);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;

    issue(1, 0, 8'h3C, 8'h00, 8'hA5, 0);
    wait_done(issued);
    drop();
    issue(0, 1, 8'h10, 8'h5A, 8'h00, 6);
    wait_done(issued);
    drop();
    issue(1, 1, 8'h20, 8'h77, 8'hC3, 0);
    wait_done(issued);
    drop();

    // Request held across mem_resp: second access follows the IDLE cycle.
    issue(1, 0, 8'h44, 8'h00, 8'h99, 0);
    wait_done(issued);
    issue(1, 0, 8'h44, 8'h00, 8'h66, 0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    drop();
    wait_done(issued);

    for (int t = 0; t < 150; t++) begin
      op = $urandom_range(0, 2);
      issue(op != 1, op != 0, 8'($urandom), 8'($urandom), 8'($urandom),
            $urandom_range(0, 8));
      wait_done(issued);
      if ($urandom_range(0, 1) == 1) begin
        drop();
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
    end
    drop();
    @(posedge clk);
    #1;

    // ext_ready stuck low.
    issue(1, 0, 8'h5E, 8'h00, 8'h12, 1000);
`ifdef TINY8_MEMCTL_TIMEOUT_EN
    wait_done(issued);
    drop();
    issue(1, 0, 8'h61, 8'h00, 8'h34, 1000);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
`else
    base = done_cnt;
    repeat (100) @(posedge clk);
    #1;
    check("no_resp_without_timeout", done_cnt, base);
    check("cs_held_in_wait", bus.ext_cs, 1);
`endif

    // Asynchronous reset in the middle of a WAIT cycle.
    #2 rst = 1'b1;
    #1;
    check("arst_ext_cs", bus.ext_cs, 0);
    check("arst_ext_we", bus.ext_we, 0);
    check("arst_mem_resp", bus.mem_resp, 0);
    check("arst_ext_addr", bus.ext_addr, 0);
    check("arst_mem_rdata", bus.mem_rdata, 0);
    sb.delete();
    issued = done_cnt;
    model_rdata = 8'h00;
    drop();
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_idle", bus.ext_cs, 0);
    issue(1, 0, 8'h3C, 8'h00, 8'h5B, 2);
    wait_done(issued);
    drop();
    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end
endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning address width.
REQ-002 SHALL have parameter DATA_W, default 8, meaning data width.
REQ-003 SHALL have parameter MIN_WAIT, default 1, range 0..15, meaning mandatory wait cycles before ext_ready is sampled.
REQ-004 SHALL have parameter TIMEOUT, default 15, range 1..255, meaning maximum cycles ext_ready may stay low (used only under REQ-024).
REQ-005 SHALL have one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  async active-high reset.
REQ-006 SHALL have mem_read  in  1  read request from control; held until mem_resp.
REQ-007 SHALL have mem_write  in  1  write request from control; held until mem_resp.
REQ-008 SHALL have mem_address  in  ADDR_W  request address.
REQ-009 SHALL have mem_wdata  in  DATA_W  write data.
REQ-010 SHALL have mem_rdata  out  DATA_W  registered read data.
REQ-011 SHALL have mem_resp  out  1  single-cycle completion pulse.
REQ-012 SHALL have mem_error  out  1  completion-with-timeout flag, valid with mem_resp.
REQ-013 SHALL have ext_cs  out  1  external chip select; ext_we  out  1  external write enable; ext_addr  out  ADDR_W; ext_wdata  out  DATA_W.
REQ-014 SHALL have ext_rdata  in  DATA_W  external read data; ext_ready  in  1  external access complete.

Function
REQ-015 SHALL implement states IDLE, SETUP, WAIT, RESP.
REQ-016 IDLE: if mem_read or mem_write is high, SHALL capture address, wdata and op into registers and go to SETUP; else stay.
REQ-017 mem_read and mem_write both high SHALL be executed as a write.
REQ-018 SETUP: SHALL assert ext_cs, ext_we (write only), and drive captured addr/wdata; SHALL go to WAIT unconditionally after one cycle.
REQ-019 WAIT: SHALL keep ext_cs/ext_we/ext_addr/ext_wdata stable; wait counter SHALL clear on entry, increment each cycle, and ext_ready SHALL be ignored until counter >= MIN_WAIT.
REQ-020 WAIT: when counter >= MIN_WAIT and ext_ready=1, SHALL latch ext_rdata into mem_rdata (reads only) and go to RESP.
REQ-021 RESP: SHALL pulse mem_resp for exactly one cycle with ext_cs=0 and return to IDLE; writes SHALL leave mem_rdata unchanged.
REQ-022 Request inputs changing after capture SHALL NOT affect the access in flight; minimum latency request-to-mem_resp SHALL be 3+MIN_WAIT cycles; the mandatory IDLE cycle after RESP SHALL prevent a held request from being re-issued in the same cycle as mem_resp.

Reset
REQ-023 rst high SHALL force, immediately and regardless of clk: state IDLE, mem_resp=0, mem_error=0, mem_rdata=0, ext_cs=0, ext_we=0, ext_addr=0, ext_wdata=0, wait counter 0; an access aborted mid-operation SHALL NOT produce mem_resp.

Configuration
REQ-024 With TINY8_MEMCTL_TIMEOUT_EN defined, WAIT SHALL go to RESP with mem_error=1 and mem_rdata=all ones (reads) when counter reaches TIMEOUT without a qualifying ext_ready; mem_error SHALL be 0 on normal completion.
REQ-025 Without TINY8_MEMCTL_TIMEOUT_EN, mem_error SHALL be constant 0, TIMEOUT SHALL be unused, and WAIT SHALL wait indefinitely for ext_ready.

Structure
REQ-026 The state enum (memctl_state) and an op enum (MEM_OP_READ, MEM_OP_WRITE) SHALL live in tiny8_types.
REQ-027 The wait/timeout counter SHALL be a sub-module mem_wait_timer (inputs clear, enable; outputs min_reached, timed_out).

Verification
REQ-028 Read, MIN_WAIT=1, addr 8'h3C, ext_ready high, ext_rdata 8'hA5 -> mem_resp 4 cycles after request, mem_rdata=8'hA5, mem_error=0.
REQ-029 Write addr 8'h10 data 8'h5A, ext_ready delayed 5 cycles -> ext_we=1, ext_addr=8'h10, ext_wdata=8'h5A stable throughout WAIT; one mem_resp pulse.
REQ-030 mem_read and mem_write both high, addr 8'h20 -> ext_we=1, write performed, mem_rdata unchanged.
REQ-031 Request held high for 3 cycles after mem_resp -> second access starts only after the IDLE cycle; exactly one mem_resp per access.
REQ-032 rst asserted in WAIT, mid-clock -> ext_cs=0 immediately, no mem_resp, next read after release completes normally.
REQ-033 TINY8_MEMCTL_TIMEOUT_EN, TIMEOUT=15, ext_ready stuck low -> mem_resp with mem_error=1, mem_rdata=8'hFF; without macro -> no mem_resp after 100 cycles.
